apb_timer_periph: RTL
=====================

// Module: apb_timer_periph
// PURPOSE
//  APB completer (slave) timer peripheral on the MCU APB bus, peer of the GPO/GPI/GPIO/RAM completers.
//  Decodes register accesses from the APB master and runs a prescaled up-counter with auto-reload.
//  Raises a level interrupt on each counter update (wrap) event.
// PARAMETERS
//  PSC_W  16  prescaler register/counter width (bits)
//  CNT_W  32  counter and auto-reload width (bits), <=32
// PORTS
//  PCLK     in   1      single clock; all state on rising edge
//  PRESET   in   1      asynchronous, active-low reset (0 = reset)
//  PADDR    in   5      byte address, bits [4:2] select register; [1:0] ignored
//  PWRITE   in   1      1 = write, 0 = read
//  PENABLE  in   1      APB access phase
//  PWDATA   in   32     write data
//  PSEL     in   1      peripheral select from APB master decoder
//  PRDATA   out  32     read data, valid while PREADY=1
//  PREADY   out  1      transfer complete
//  irq      out  1      interrupt = SR.UIF & CR.IE (plus CCIF & IE with option)
//  cap_in   in   1      capture input, present only with APB_TIMER_CAPTURE_EN
// BEHAVIOUR
//  Register map (unlisted offsets read 0, writes ignored, no error):
//   0x00 CR  [0]EN [1]OPM one-shot [2]IE; rest RAZ/WI     reset 0
//   0x04 PSC [PSC_W-1:0] tick every PSC+1 PCLK              reset 0
//   0x08 ARR [CNT_W-1:0] counter wrap value                 reset all-ones
//   0x0C CNT [CNT_W-1:0] counter, R/W                       reset 0
//   0x10 SR  [0]UIF [1]CCIF; write-1-to-clear               reset 0
//  APB handshake (one wait state, every access):
//   - cycle A: PSEL&PENABLE seen, PREADY=0 -> register performs write / samples read data,
//     PREADY<=1, PRDATA<=selected register.
//   - cycle B: PREADY=1, PRDATA valid; master ends transfer; PREADY<=0 next cycle.
//   - Write takes effect at end of cycle A; never executes twice per transfer.
//   - PRDATA holds last value when PREADY=0. PSEL without PENABLE: no action.
//  Reset: PREADY=0, PRDATA=0, irq=0, all registers to reset values, prescaler count=0.
//  Counting (CR.EN=1):
//   - psc_cnt counts 0..PSC; tick when psc_cnt==PSC, then psc_cnt<=0. PSC=0 -> tick every cycle.
//   - On tick: if CNT==ARR -> CNT<=0, UIF<=1, and if OPM then EN<=0; else CNT<=CNT+1.
//   - ARR=0 -> update event on every tick. CNT>ARR (written) -> counts up to all-ones, wraps to 0
//     with update event.
//  CR.EN=0: psc_cnt and CNT hold; no events.
//  Writes to PSC or CNT clear psc_cnt to 0.
//  Simultaneous events in one cycle:
//   - APB write to CNT vs tick: write wins.
//   - Hardware UIF set vs W1C clear: set wins.
//   - OPM auto-clear of EN vs APB write of CR: APB write wins.
//  irq is registered-free: combinational AND of SR and CR.IE; deasserts same cycle UIF clears.
//  Async reset mid-transfer aborts it; PREADY drops immediately; master must restart.
// CONFIGURATION
//  APB_TIMER_CAPTURE_EN defined:
//   - adds cap_in, two-flop synchronised.
//   - On synchronised rising edge: CCR(0x14)<=CNT and SR.CCIF<=1.
//   - irq also asserted by CCIF&IE.
//   - Edge coincident with CCIF W1C: set wins.
//  Not defined: cap_in absent; 0x14 reads 0; SR[1] reads 0.
// TESTING
//  1. Reset then read all regs -> CR=0, PSC=0, ARR=0xFFFF_FFFF, CNT=0, SR=0; every PREADY after exactly 1 wait state.
//  2. PSC=3, ARR=4, CR=0x5 -> CNT increments every 4 PCLK; UIF=1 and irq=1 at 20th cycle after enable, CNT back to 0.
//  3. Write SR=0x1 -> UIF=0, irq=0; repeat W1C on same cycle as wrap -> UIF stays 1.
//  4. PSC=0, ARR=2, CR=0x3 (OPM) -> CNT 0,1,2,0 then EN reads 0, CNT holds 0, UIF=1.
//  5. Counting with ARR=10: write CNT=7 on a tick cycle -> next read 7; read 0x18 -> 0, write ignored.
//  6. With APB_TIMER_CAPTURE_EN: PSC=0, CNT running, pulse cap_in -> CCR = CNT from 2-3 cycles after edge, CCIF=1.

Source files
------------

// File: rtl/apb_timer_periph.sv
// APB completer timer: prescaled up-counter with auto-reload and level interrupt on wrap.
// Optional input capture (cap_in, CCR at 0x14, SR.CCIF) enabled by defining APB_TIMER_CAPTURE_EN.
module apb_timer_periph #(
  parameter int PSC_W = 16,
  parameter int CNT_W = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
`ifdef APB_TIMER_CAPTURE_EN
  input  logic        cap_in,
`endif
  output logic        irq
);

  localparam logic [2:0] A_CR  = 3'd0;
  localparam logic [2:0] A_PSC = 3'd1;
  localparam logic [2:0] A_ARR = 3'd2;
  localparam logic [2:0] A_CNT = 3'd3;
  localparam logic [2:0] A_SR  = 3'd4;
`ifdef APB_TIMER_CAPTURE_EN
  localparam logic [2:0] A_CCR = 3'd5;
`endif

  logic             cr_en, cr_opm, cr_ie;
  logic [PSC_W-1:0] psc, psc_cnt;
  logic [CNT_W-1:0] arr, cnt;
  logic             uif;
  logic [31:0]      rdata;

  // Access phase is acted on only while PREADY is low, so each transfer executes once.
  logic       access, wr;
  logic [2:0] sel;
  logic       wr_cr, wr_psc, wr_arr, wr_cnt, wr_sr;
  logic       tick, at_top, upd;

  assign access = PSEL & PENABLE & ~PREADY;
  assign wr     = access & PWRITE;
  assign sel    = PADDR[4:2];
  assign wr_cr  = wr && (sel == A_CR);
  assign wr_psc = wr && (sel == A_PSC);
  assign wr_arr = wr && (sel == A_ARR);
  assign wr_cnt = wr && (sel == A_CNT);
  assign wr_sr  = wr && (sel == A_SR);

  logic unused_addr_bits;
  assign unused_addr_bits = ^PADDR[1:0];

  assign tick   = cr_en && (psc_cnt == psc);
  // A counter written above ARR runs on to all-ones before wrapping.
  assign at_top = (cnt == arr) || (cnt == '1);
  assign upd    = tick && at_top && !wr_cnt;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
    end else begin
      PREADY <= access;
      if (access) PRDATA <= rdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      cr_en  <= 1'b0;
      cr_opm <= 1'b0;
      cr_ie  <= 1'b0;
      psc    <= '0;
      arr    <= '1;
    end else begin
      if (wr_cr) begin
        cr_en  <= PWDATA[0];
        cr_opm <= PWDATA[1];
        cr_ie  <= PWDATA[2];
      end else if (upd && cr_opm) begin
        cr_en <= 1'b0;
      end
      if (wr_psc) psc <= PWDATA[PSC_W-1:0];
      if (wr_arr) arr <= PWDATA[CNT_W-1:0];
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      psc_cnt <= '0;
      cnt     <= '0;
      uif     <= 1'b0;
    end else begin
      if (wr_psc || wr_cnt)  psc_cnt <= '0;
      else if (cr_en)        psc_cnt <= tick ? '0 : psc_cnt + 1'b1;

      if (wr_cnt)            cnt <= PWDATA[CNT_W-1:0];
      else if (tick)         cnt <= at_top ? '0 : cnt + 1'b1;

      if (upd)                        uif <= 1'b1;
      else if (wr_sr && PWDATA[0])    uif <= 1'b0;
    end
  end

`ifdef APB_TIMER_CAPTURE_EN
  logic [2:0]       cap_sync;
  logic             cap_rise;
  logic             ccif;
  logic [CNT_W-1:0] ccr;

  assign cap_rise = cap_sync[1] & ~cap_sync[2];

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      cap_sync <= '0;
      ccif     <= 1'b0;
      ccr      <= '0;
    end else begin
      cap_sync <= {cap_sync[1:0], cap_in};
      if (cap_rise) begin
        ccr  <= cnt;
        ccif <= 1'b1;
      end else if (wr_sr && PWDATA[1]) begin
        ccif <= 1'b0;
      end
    end
  end

  assign irq = cr_ie & (uif | ccif);
`else
  assign irq = cr_ie & uif;
`endif

  always_comb begin
    rdata = '0;
    case (sel)
      A_CR:  rdata[2:0]       = {cr_ie, cr_opm, cr_en};
      A_PSC: rdata[PSC_W-1:0] = psc;
      A_ARR: rdata[CNT_W-1:0] = arr;
      A_CNT: rdata[CNT_W-1:0] = cnt;
      A_SR: begin
        rdata[0] = uif;
`ifdef APB_TIMER_CAPTURE_EN
        rdata[1] = ccif;
`endif
      end
`ifdef APB_TIMER_CAPTURE_EN
      A_CCR: rdata[CNT_W-1:0] = ccr;
`endif
      default: rdata = '0;
    endcase
  end

endmodule
